// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

    // Double-dabble digit correction: a digit of 5..9 becomes 8..12 so the next shift carries.
    function automatic logic [BCD_DIGIT_W-1:0] add3_if_ge5(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= 4'd5) ? 4'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/dabble_stage.sv
// One combinational double-dabble step: adjust every digit, then shift one new bit in.
module dabble_stage
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] digits,
    input  logic                          shift_bit,
    output logic [BCD_DIGIT_W*DIGITS-1:0] shifted_c,
    output logic                          carry_c
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

    logic [BCD_W-1:0] adjusted;

    // Independent per-digit add-3 correction; no carry propagates between digits.
    always_comb begin
        adjusted = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adjusted[i*BCD_DIGIT_W +: BCD_DIGIT_W] = add3_if_ge5(digits[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // The adjusted top bit leaves the digit field and becomes the overflow carry.
    assign shifted_c = {adjusted[BCD_W-2:0], shift_bit};
    assign carry_c   = adjusted[BCD_W-1];

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per clock, with signed mode and sticky overflow.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    input  logic                          signed_mode,
    output logic                          ready,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          neg,
    output logic                          overflow
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    bcd_state_t       state, state_nx;
    logic             ready_nx, valid_nx, neg_nx, overflow_nx;
    logic [BCD_W-1:0] bcd_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [BIN_W-1:0] mag, mag_nx;
    logic [BCD_W-1:0] step_bcd;
    logic             step_carry;
    logic             is_neg;

    dabble_stage #(
        .DIGITS(DIGITS)
    ) u_stage (
        .digits   (bcd),
        .shift_bit(mag[BIN_W-1]),
        .shifted_c(step_bcd),
        .carry_c  (step_carry)
    );

    assign is_neg = signed_mode & bin[BIN_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and next datapath/output values; everything holds unless a state acts on it.
    always_comb begin
        state_nx    = state;
        ready_nx    = ready;
        valid_nx    = valid;
        bcd_nx      = bcd;
        neg_nx      = neg;
        overflow_nx = overflow;
        cnt_nx      = cnt;
        mag_nx      = mag;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    // Most-negative operand negates to itself, which is the correct unsigned magnitude.
                    mag_nx      = is_neg ? BIN_W'(-bin) : bin;
                    neg_nx      = is_neg;
                    bcd_nx      = '0;
                    overflow_nx = 1'b0;
                    cnt_nx      = CNT_W'(BIN_W);
                    ready_nx    = 1'b0;
                    valid_nx    = 1'b0;
                    state_nx    = CONVERT;
                end
            end
            CONVERT: begin
                bcd_nx      = step_bcd;
                mag_nx      = {mag[BIN_W-2:0], 1'b0};
                overflow_nx = overflow | step_carry;
                cnt_nx      = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    ready_nx = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = DONE;
                end
            end
            default: begin
                ready_nx = 1'b1;
                valid_nx = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b1;
            valid    <= 1'b0;
            bcd      <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            mag      <= '0;
        end else begin
            ready    <= ready_nx;
            valid    <= valid_nx;
            bcd      <= bcd_nx;
            neg      <= neg_nx;
            overflow <= overflow_nx;
            cnt      <= cnt_nx;
            mag      <= mag_nx;
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
It replaces the single-cycle combinational converter wherever wide operands or timing closure make a one-cycle unrolled chain unacceptable.
Adds a start/ready/valid handshake, a signed (two's complement) mode with sign output, and a sticky overflow flag.
Sits between the datapath result register and the seven-segment display driver.

Parameters:
BIN_W, 14, width of binary operand in bits (≥2)
DIGITS, 4, number of BCD output digits; output width 4*DIGITS

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  request conversion; accepted only when ready=1
bin  in  BIN_W  operand, sampled on the accepting edge only
signed_mode  in  1  1: bin is two's complement; sampled with bin
ready  out  1  high in IDLE and DONE
valid  out  1  high in DONE; bcd/neg/overflow stable while high
bcd  out  4*DIGITS  result digits, digit 0 in [3:0]
neg  out  1  result negative (signed_mode and bin MSB set)
overflow  out  1  magnitude ≥ 10^DIGITS; bcd holds magnitude mod 10^DIGITS

Behaviour:
- Clock/reset: one clock domain, clk. Reset (rst) is synchronous and active-high.
- Reset: state=IDLE, ready=1, valid=0, bcd=0, neg=0, overflow=0, bit counter=0, operand shift register=0. Reset mid-conversion aborts at once; no partial result is visible.
- States: IDLE, CONVERT, DONE.
- IDLE/DONE with start=1 (edge N):
  - latch mag = (signed_mode && bin[BIN_W-1]) ? -bin : bin, as a BIN_W-bit unsigned value;
  - latch neg; clear bcd and overflow; counter=BIN_W; go to CONVERT.
  - ready and valid drop after edge N.
- CONVERT, each edge:
  - for every digit d, if d≥5 then d=d+3 (4-bit, no carry between digits);
  - shift {carry_out, bcd, mag} left by one; carry_out = old bcd MSB after adjust;
  - overflow |= carry_out;
  - counter decrements. On the edge where counter reaches 0, go to DONE.
- Latency: valid is high after edge N+BIN_W, i.e. BIN_W cycles after the accepting edge. Back-to-back throughput is one result per BIN_W+... cycles: start may be asserted in the same cycle valid is high.
- DONE: valid=1, ready=1, outputs held indefinitely until the next accepted start or rst.
- start while in CONVERT: ignored, with no effect on state or outputs; the requester must hold or re-issue it.
- signed_mode=0: neg is forced to 0 and the MSB is treated as magnitude.
- Most-negative input (-2^(BIN_W-1)): its magnitude 2^(BIN_W-1) fits in BIN_W unsigned bits and must convert correctly.
- Overflow is sticky only within one conversion. bcd always holds the low DIGITS digits of the magnitude.
- start and rst in the same cycle: rst wins.

Decomposition:
- Package bcd_pkg holds:
  - localparam BCD_DIGIT_W=4;
  - typedef enum for IDLE/CONVERT/DONE;
  - function add3_if_ge5(input [3:0]) returning [3:0].
- One natural sub-module: dabble_stage, a combinational adjust-and-shift across DIGITS digits. It is reusable by future pipelined variants and is instantiated once here.

Test Plan:
1. BIN_W=14, DIGITS=4, unsigned bin=9999: start once → valid exactly 14 cycles later, bcd=16'h9999, overflow=0, neg=0.
2. Unsigned bin=16383 → bcd=16'h6383, overflow=1. Follow with a start of bin=0 issued while valid=1 → bcd=16'h0000, overflow cleared.
3. signed_mode=1, bin=14'h3B2E (−1234) → bcd=16'h1234, neg=1. Then bin=14'h2000 (−8192) → bcd=16'h8192, neg=1, overflow=0.
4. Pulse start again 5 cycles into a conversion of 4321 with bin=7777 → result 16'h4321, valid still at cycle 14, second request ignored.
5. Assert rst at cycle 7 of a conversion → next cycle: IDLE, ready=1, valid=0, bcd=0. A fresh start of 42 → 16'h0042 after 14 cycles.
6. Reparametrise BIN_W=20, DIGITS=6, bin=999999 → bcd=24'h999999 after 20 cycles, overflow=0. Then bin=1048575 → 24'h048575, overflow=1.
